decrypt_stream_unit: RTL and testbench

//  Receive side of the encrypt/decrypt datapath; sits directly downstream of encrypt_unit.

---
 rtl/decrypt_stream_unit.sv | 124 ++++++++++++
 tb/tb_decrypt_stream_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_stream_unit.sv
`default_nettype none
// ============================================================================
// decrypt_stream_unit : strips the rotating 3-key XOR from an encrypted byte
//                       stream and buffers plaintext behind valid/ready.
// Revision: 1.0
// ============================================================================
module decrypt_stream_unit #(
  parameter logic [7:0] KEY0  = 8'hA5,
  parameter logic [7:0] KEY1  = 8'h3C,
  parameter logic [7:0] KEY2  = 8'h5A,
  parameter int         DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_v,
  input  logic [7:0] din,
  input  logic       key_sync,
  output logic       in_rdy,
  output logic       out_v,
  output logic [7:0] dout,
  input  logic       out_rdy,
  output logic [7:0] drop_cnt
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [1:0]    k_q, k_d, k_cur;
  logic          s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [7:0]    s1_data_q, s1_data_d, s2_data_q, s2_data_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic [CW:0]   occ;
  logic [7:0]    key_byte;
  logic          accept, drop, push, pop;

  // Pipeline stages reserve FIFO space, so the tail write can never overflow.
  always_comb begin
    occ    = {1'b0, count_q} + {{CW{1'b0}}, s1_v_q} + {{CW{1'b0}}, s2_v_q};
    in_rdy = (occ < DEPTH_C);
    accept = in_v && in_rdy;
    drop   = in_v && !in_rdy;
    out_v  = (count_q != '0);
    push   = s2_v_q;
    pop    = out_v && out_rdy;
    dout   = out_v ? mem_q[rd_ptr_q] : 8'h00;
    drop_cnt = drop_cnt_q;
  end

  // Key rotation follows every presented byte, accepted or dropped.
  always_comb begin
    k_cur = key_sync ? 2'd0 : k_q;
    case (k_cur)
      2'd0:    key_byte = KEY0;
      2'd1:    key_byte = KEY1;
      default: key_byte = KEY2;
    endcase
    k_d = k_q;
    if (in_v)          k_d = (k_cur == 2'd2) ? 2'd0 : k_cur + 2'd1;
    else if (key_sync) k_d = 2'd0;
  end

  always_comb begin
    s1_v_d    = accept;
    s1_data_d = din ^ key_byte;
    s2_v_d    = s1_v_q;
    s2_data_d = s1_data_q;

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s2_data_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= 2'd0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s1_data_q  <= 8'h00;
      s2_data_q  <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= 8'h00;
    end else begin
      k_q        <= k_d;
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: dout is gated by out_v.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_decrypt_stream_unit.sv
`default_nettype none
// ============================================================================
// tb_decrypt_stream_unit : scoreboard bench for decrypt_stream_unit.
// Revision: 1.0
// ============================================================================
module tb_decrypt_stream_unit;

  localparam logic [7:0] KEY0 = 8'hA5;
  localparam logic [7:0] KEY1 = 8'h3C;
  localparam logic [7:0] KEY2 = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_v;
  logic [7:0] din;
  logic       key_sync;
  logic       in_rdy;
  logic       out_v;
  logic [7:0] dout;
  logic       out_rdy;
  logic [7:0] drop_cnt;

  decrypt_stream_unit #(.KEY0(KEY0), .KEY1(KEY1), .KEY2(KEY2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_v(in_v), .din(din), .key_sync(key_sync),
    .in_rdy(in_rdy), .out_v(out_v), .dout(dout), .out_rdy(out_rdy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   bk    = 0;
  bit   lat_mode = 1'b0;
  bit   mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] kf(input int idx);
    case (idx)
      0:       return KEY0;
      1:       return KEY1;
      default: return KEY2;
    endcase
  endfunction

  // Entered and left at posedge+1.
  task automatic drive(input logic v, input logic [7:0] d, input logic s,
                       input logic acc, input logic [7:0] e);
    int due;
    due      = cyc + 3;
    in_v     = v;
    din      = d;
    key_sync = s;
    @(negedge clk);
    if (v) begin
      chk_val("in_rdy", {31'b0, in_rdy}, {31'b0, acc});
      if (acc) q.push_back('{data: e, due: due});
    end
    @(posedge clk); #1;
    in_v     = 1'b0;
    din      = 8'h00;
    key_sync = 1'b0;
  endtask

  task automatic send_ct(input logic [7:0] ct, input logic s, input logic acc);
    int idx;
    idx = s ? 0 : bk;
    bk  = (idx == 2) ? 0 : idx + 1;
    drive(1'b1, ct, s, acc, ct ^ kf(idx));
  endtask

  // Bench-side encryptor: plaintext in, expect the same plaintext out.
  task automatic send_pt(input logic [7:0] pt);
    int idx;
    idx = bk;
    bk  = (idx == 2) ? 0 : idx + 1;
    drive(1'b1, pt ^ kf(idx), 1'b0, 1'b1, pt);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle_sync();
    bk = 0;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      idle(1);
      n++;
    end
    chk_val("drain_left", q.size(), 0);
  endtask

  // Monitor: pop on handshake, verify hold under backpressure and timing.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (q.size() == 0) begin
        chk_val("out_v_idle", {31'b0, out_v}, 0);
      end else begin
        if (lat_mode && q[0].due == cyc) chk_val("out_v_due", {31'b0, out_v}, 1);
        if (out_v) begin
          chk_val("dout", {24'b0, dout}, {24'b0, q[0].data});
          if (out_rdy) begin
            if (lat_mode) chk_val("latency", cyc, q[0].due);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_v = 1'b0; din = 8'h00; key_sync = 1'b0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_val("rst_out_v", {31'b0, out_v}, 0);
    chk_val("rst_dout", {24'b0, dout}, 0);
    chk_val("rst_in_rdy", {31'b0, in_rdy}, 1);
    chk_val("rst_drop", {24'b0, drop_cnt}, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // T1: FF x4 with default keys -> 5A,C3,A5,5A at fixed latency
    lat_mode = 1'b1;
    repeat (4) send_ct(8'hFF, 1'b0, 1'b1);
    drain(20);

    // T4: key_sync on the third byte -> 5A,C3,5A,C3
    idle_sync();
    send_ct(8'hFF, 1'b0, 1'b1);
    send_ct(8'hFF, 1'b0, 1'b1);
    send_ct(8'hFF, 1'b1, 1'b1);
    send_ct(8'hFF, 1'b0, 1'b1);
    drain(20);

    // T2: 200 random plaintext bytes through the encryptor model, with a gap
    for (int i = 0; i < 200; i++) begin
      if (i == 100) idle(3);
      send_pt(8'($urandom_range(0, 255)));
    end
    drain(20);
    chk_val("t2_drop", {24'b0, drop_cnt}, 0);

    // T3: overflow with consumer stalled; key stays aligned across drops
    lat_mode = 1'b0;
    idle_sync();
    out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) send_ct(8'(8'h11 * (i + 1)), 1'b0, i < 4);
    chk_val("t3_drop", {24'b0, drop_cnt}, 2);
    idle(2);
    chk_val("t3_in_rdy_full", {31'b0, in_rdy}, 0);
    out_rdy = 1'b1;
    drain(20);
    send_ct(8'h77, 1'b0, 1'b1);
    drain(20);

    // T5: mid-stream reset with bytes buffered
    out_rdy = 1'b0;
    idle_sync();
    repeat (3) send_ct(8'hFF, 1'b0, 1'b1);
    idle(3);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bk  = 0;
    @(negedge clk);
    chk_val("t5_out_v", {31'b0, out_v}, 0);
    chk_val("t5_drop", {24'b0, drop_cnt}, 0);
    chk_val("t5_in_rdy", {31'b0, in_rdy}, 1);
    @(posedge clk); #1;
    out_rdy  = 1'b1;
    lat_mode = 1'b1;
    send_ct(8'hFF, 1'b0, 1'b1);
    drain(20);

    // T6: drop counter saturation
    lat_mode = 1'b0;
    out_rdy  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send_ct(8'(i), 1'b0, i < 4);
      if (i == 99)  chk_val("t6_drop_mid", {24'b0, drop_cnt}, 32'h60);
      if (i == 258) chk_val("t6_drop_sat", {24'b0, drop_cnt}, 32'hFF);
    end
    chk_val("t6_drop_end", {24'b0, drop_cnt}, 32'hFF);
    out_rdy = 1'b1;
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
